// File: rtl/j1_io_hub.sv
// rtl/j1_io_hub.sv - J1 I/O hub: registered write decode, UART TX/RX FIFO, LEDs, debounced keys
module j1_io_hub #(
    parameter int LEDS            = 4,
    parameter bit LED_ACTIVE_LOW  = 1'b1,
    parameter int KEYS            = 2,
    parameter bit KEY_IDLE        = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic            io_wr,
    input  logic [15:0]     mem_addr,
    input  logic [31:0]     dout,
    output logic [31:0]     io_din,
    input  logic            uart_rx_valid,
    input  logic [7:0]      uart_rx_data,
    output logic            uart_rx_rd,
    input  logic            uart_tx_busy,
    output logic            uart_tx_wr,
    output logic [7:0]      uart_tx_data,
    input  logic [KEYS-1:0] keys,
    output logic [LEDS-1:0] leds
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_HOLD} rx_state_e;

    logic                      wr_q, wr_d;
    logic [15:0]               addr_q, addr_d;
    logic [31:0]               dout_q, dout_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic [LEDS-1:0]           led_q, led_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic                      ovf_q, ovf_d;
    rx_state_e                 state_q, state_d;
    logic                      rx_rd_q, rx_rd_d;
    logic [KEYS-1:0]           sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
    logic [KEYS-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [7:0]                mem_q [FIFO_DEPTH];

    logic tx_sel, pop_sel, led_sel, ctrl_sel;
    logic flush, ovf_clr, fifo_empty, fifo_full, accept, push, pop;
    logic [7:0] keys_ext, head_byte, count_ext;
    logic unused_dout_bits;

    assign tx_sel     = wr_q && (addr_q == 16'h0000);
    assign pop_sel    = wr_q && (addr_q == 16'h0002);
    assign led_sel    = wr_q && (addr_q == 16'h0004);
    assign ctrl_sel   = wr_q && (addr_q == 16'h0006);
    assign flush      = ctrl_sel && dout_q[0];
    assign ovf_clr    = ctrl_sel && dout_q[1];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // A flush cycle blocks the drain so the byte waits in buart for the next cycle.
    assign accept     = (state_q == S_IDLE) && uart_rx_valid && !flush;
    assign push       = accept && !fifo_full;
    assign pop        = pop_sel && !fifo_empty && !flush;
    assign unused_dout_bits = ^dout_q[31:8];

    always_comb begin
        wr_d      = io_wr;
        addr_d    = mem_addr;
        dout_d    = dout;
        tx_data_d = tx_sel ? dout_q[7:0] : tx_data_q;
        led_d     = led_q;
        if (led_sel) begin
            led_d = LED_ACTIVE_LOW ? ~dout_q[LEDS-1:0] : dout_q[LEDS-1:0];
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        ovf_d = ovf_q;
        if (accept && fifo_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        state_d = state_q;
        rx_rd_d = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                rx_rd_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        sync1_d = keys;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < KEYS; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                deb_d[k] = sync2_q[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            tx_data_q <= '0;
            led_q     <= {LEDS{LED_ACTIVE_LOW}};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            rx_rd_q   <= 1'b0;
            sync1_q   <= {KEYS{KEY_IDLE}};
            sync2_q   <= {KEYS{KEY_IDLE}};
            deb_q     <= {KEYS{KEY_IDLE}};
            cnt_q     <= '0;
        end else begin
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            tx_data_q <= tx_data_d;
            led_q     <= led_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            rx_rd_q   <= rx_rd_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_rx_data;
        end
    end

    always_comb begin
        keys_ext             = '0;
        keys_ext[KEYS-1:0]   = deb_q;
        count_ext            = '0;
        count_ext[AW:0]      = count_q;
        head_byte            = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
        io_din = {count_ext, head_byte, 4'b0000, fifo_full, ovf_q, !fifo_empty,
                  uart_tx_busy, keys_ext};
    end

    assign uart_tx_wr   = tx_sel;
    assign uart_tx_data = tx_data_d;
    assign uart_rx_rd   = rx_rd_q;
    assign leds         = led_q;
endmodule
